// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: per-channel reset sequencing, lock qualification,
// timeout/retry handling and a combined downstream reset.
// Optional feature macro: PLL_LOSS_COUNT_EN enables the saturating
// lock-loss counter on loss_cnt_o; without it loss_cnt_o is tied to zero.
module pll_lock_supervisor #(
   parameter int NUM_PLL          = 1,
   parameter int RST_PULSE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES   = 27000,
   parameter int STABLE_CYCLES    = 2700,
   parameter int MAX_RETRY        = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_PLL-1:0] lock_i,
   input  logic [NUM_PLL-1:0] retry_i,
   output logic [NUM_PLL-1:0] pll_rst_o,
   output logic [NUM_PLL-1:0] ready_o,
   output logic [NUM_PLL-1:0] fail_o,
   output logic               sys_rst_n_o,
   output logic [7:0]         loss_cnt_o
);

   localparam int MAX_RT = (RST_PULSE_CYCLES > TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : TIMEOUT_CYCLES;
   localparam int MAX_T  = (MAX_RT > STABLE_CYCLES) ? MAX_RT : STABLE_CYCLES;
   localparam int CW     = $clog2(MAX_T) + 1;
   localparam int RW     = $clog2(MAX_RETRY + 1);

   localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

   typedef enum logic [2:0] {
      ST_RST,
      ST_WAIT,
      ST_STABLE,
      ST_LOCKED,
      ST_FAIL
   } state_e;

   logic [NUM_PLL-1:0] sync1_q;
   logic [NUM_PLL-1:0] lk_q;
   logic               sys_q;

`ifdef PLL_LOSS_COUNT_EN
   logic [NUM_PLL-1:0] loss_evt;
`endif

   // Two-flop synchroniser for the asynchronous PLL lock outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         lk_q    <= '0;
      end else begin
         sync1_q <= lock_i;
         lk_q    <= sync1_q;
      end
   end

   for (genvar g = 0; g < NUM_PLL; g++) begin : g_ch
      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [RW-1:0] retry_q, retry_d;

      // Channel state, cycle counter and retry counter registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            retry_q <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
         end
      end

      // Channel next-state: reset pulse, lock wait, stability window, lock watch
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         retry_d = retry_q;
         case (state_q)
            ST_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = ST_WAIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (lk_q[g]) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TO_LAST) begin
                  cnt_d   = '0;
                  retry_d = retry_q + 1'b1;
                  state_d = (retry_q == RETRY_LAST) ? ST_FAIL : ST_RST;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_STABLE: begin
               if (!lk_q[g]) begin
                  state_d = ST_WAIT;
                  cnt_d   = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = ST_LOCKED;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!lk_q[g]) begin
                  state_d = ST_RST;
                  cnt_d   = '0;
               end
            end
            ST_FAIL: begin
               if (retry_i[g]) begin
                  state_d = ST_RST;
                  cnt_d   = '0;
                  retry_d = '0;
               end
            end
            default: begin
               state_d = ST_RST;
               cnt_d   = '0;
               retry_d = '0;
            end
         endcase
      end

      assign pll_rst_o[g] = (state_q == ST_RST) || (state_q == ST_FAIL);
      assign ready_o[g]   = (state_q == ST_LOCKED);
      assign fail_o[g]    = (state_q == ST_FAIL);
`ifdef PLL_LOSS_COUNT_EN
      assign loss_evt[g]  = (state_q == ST_LOCKED) && !lk_q[g];
`endif
   end

   // Downstream reset released one cycle after every channel is ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sys_q <= 1'b0;
      end else begin
         sys_q <= &ready_o;
      end
   end

   assign sys_rst_n_o = sys_q;

`ifdef PLL_LOSS_COUNT_EN
   logic [7:0] loss_q, loss_d;
   logic [2:0] n_loss;
   logic [8:0] loss_sum;

   // Sum simultaneous loss events and saturate at 255
   always_comb begin
      n_loss = '0;
      for (int unsigned i = 0; i < NUM_PLL; i++) begin
         n_loss = n_loss + {2'b00, loss_evt[i]};
      end
      loss_sum = {1'b0, loss_q} + {6'b000000, n_loss};
      loss_d   = loss_sum[8] ? 8'hFF : loss_sum[7:0];
   end

   // Loss counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign loss_cnt_o = loss_q;
`else
   assign loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor (2 channels, short timings).
module tb_pll_lock_supervisor;

   localparam int NP = 2;
   localparam int RP = 4;
   localparam int TO = 64;
   localparam int ST = 16;
   localparam int MR = 3;

`ifdef PLL_LOSS_COUNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NP-1:0] lock;
   logic [NP-1:0] retry;
   logic [NP-1:0] pll_rst;
   logic [NP-1:0] ready;
   logic [NP-1:0] fail;
   logic          sys_rst_n;
   logic [7:0]    loss_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];

   pll_lock_supervisor #(
      .NUM_PLL          (NP),
      .RST_PULSE_CYCLES (RP),
      .TIMEOUT_CYCLES   (TO),
      .STABLE_CYCLES    (ST),
      .MAX_RETRY        (MR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lock_i      (lock),
      .retry_i     (retry),
      .pll_rst_o   (pll_rst),
      .ready_o     (ready),
      .fail_o      (fail),
      .sys_rst_n_o (sys_rst_n),
      .loss_cnt_o  (loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      lock  = '0;
      retry = '0;
      repeat (3) tick();
   endtask

   task automatic wait_ready_all(output int n);
      n = 0;
      while (ready !== 2'b11 && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pll_rst !== 2'b11) begin failures++; $display("FAIL reset_pll_rst got=%b exp=11", pll_rst); end
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", ready); end
      checks++; if (fail !== 2'b00) begin failures++; $display("FAIL reset_fail got=%b exp=00", fail); end
      checks++; if (sys_rst_n !== 1'b0) begin failures++; $display("FAIL reset_sys got=%b exp=0", sys_rst_n); end
      checks++; if (loss_cnt !== 8'd0) begin failures++; $display("FAIL reset_loss got=%0d exp=0", loss_cnt); end
   endtask

   task automatic test_bringup();
      int n, exp;
      rst_n = 1'b1;
      for (int i = 1; i <= RP; i++) begin
         tick();
         exp = (i < RP) ? 2'b11 : 2'b00;
         checks++; if (pll_rst !== 2'(exp)) begin failures++; $display("FAIL bringup_pll_rst tick=%0d got=%b exp=%b", i, pll_rst, 2'(exp)); end
      end
      repeat (10 - RP) tick();
      lock = 2'b11;
      // one tick reaches the sampling edge, then 2 + STABLE edges
      exp_q.push_back(1 + 2 + ST);
      exp_q.push_back(1);
      wait_ready_all(n);
      exp = exp_q.pop_front();
      checks++; if (n != exp) begin failures++; $display("FAIL bringup_ready_latency got=%0d exp=%0d", n, exp); end
      n = 0;
      while (sys_rst_n !== 1'b1 && n < 10) begin tick(); n++; end
      exp = exp_q.pop_front();
      checks++; if (n != exp) begin failures++; $display("FAIL bringup_sys_latency got=%0d exp=%0d", n, exp); end
   endtask

   task automatic test_loss();
      int n, exp;
      lock[1] = 1'b0;
      exp_q.push_back(3);
      tick();
      lock[1] = 1'b1;
      n = 1;
      while (ready[1] !== 1'b0 && n < 20) begin tick(); n++; end
      exp = exp_q.pop_front();
      checks++; if (n != exp) begin failures++; $display("FAIL loss_ready_fall got=%0d exp=%0d", n, exp); end
      checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL loss_ready0 got=%b exp=1", ready[0]); end
      checks++; if (sys_rst_n !== 1'b1) begin failures++; $display("FAIL loss_sys_same_cycle got=%b exp=1", sys_rst_n); end
      tick();
      checks++; if (sys_rst_n !== 1'b0) begin failures++; $display("FAIL loss_sys_fall got=%b exp=0", sys_rst_n); end
      checks++; if (loss_cnt !== (LOSS_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL loss_count got=%0d exp=%0d", loss_cnt, LOSS_EN ? 1 : 0); end
      // pll_rst[1] was already high for one sample before this tick
      n = 1;
      while (pll_rst[1] === 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n != RP) begin failures++; $display("FAIL loss_rst_pulse got=%0d exp=%0d", n, RP); end
      wait_ready_all(n);
      checks++; if (ready !== 2'b11) begin failures++; $display("FAIL loss_relock got=%b exp=11", ready); end
   endtask

   task automatic test_glitch();
      int bad;
      bad = 0;
      @(posedge clk);
      #2 lock[0] = 1'b0;
      #3 lock[0] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (ready !== 2'b11) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL glitch_ready_drops got=%0d exp=0", bad); end
   endtask

   task automatic test_stable_drop();
      int r0, r1, exp;
      do_reset();
      rst_n = 1'b1;
      repeat (6) tick();
      lock = 2'b11;
      exp_q.push_back(1 + 32);
      exp_q.push_back(1 + 2 + ST);
      r0 = -1;
      r1 = -1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 13) lock[0] = 1'b0;
         if (k == 14) lock[0] = 1'b1;
         if (r0 < 0 && ready[0] === 1'b1) r0 = k;
         if (r1 < 0 && ready[1] === 1'b1) r1 = k;
      end
      exp = exp_q.pop_front();
      checks++; if (r0 != exp) begin failures++; $display("FAIL stable_drop_ch0 got=%0d exp=%0d", r0, exp); end
      exp = exp_q.pop_front();
      checks++; if (r1 != exp) begin failures++; $display("FAIL stable_drop_ch1 got=%0d exp=%0d", r1, exp); end
   endtask

   task automatic test_fail_retry();
      int k_fail, hi, n, exp;
      do_reset();
      lock = 2'b10;
      rst_n = 1'b1;
      exp_q.push_back(MR * (RP + TO));
      exp_q.push_back(RP - 1 + (MR - 1) * RP);
      k_fail = -1;
      hi = 0;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (fail[0] === 1'b1) begin k_fail = k; break; end
         if (pll_rst[0] === 1'b1) hi++;
      end
      exp = exp_q.pop_front();
      checks++; if (k_fail != exp) begin failures++; $display("FAIL fail_time got=%0d exp=%0d", k_fail, exp); end
      exp = exp_q.pop_front();
      checks++; if (hi != exp) begin failures++; $display("FAIL fail_rst_cycles got=%0d exp=%0d", hi, exp); end
      repeat (10) tick();
      checks++; if (fail !== 2'b01) begin failures++; $display("FAIL fail_sticky got=%b exp=01", fail); end
      checks++; if (pll_rst !== 2'b01) begin failures++; $display("FAIL fail_parked got=%b exp=01", pll_rst); end
      checks++; if (ready !== 2'b10) begin failures++; $display("FAIL fail_ch1_ready got=%b exp=10", ready); end
      retry = 2'b11;
      tick();
      retry = 2'b00;
      checks++; if (fail !== 2'b00) begin failures++; $display("FAIL retry_fail_clear got=%b exp=00", fail); end
      checks++; if (ready !== 2'b10) begin failures++; $display("FAIL retry_ignored_ch1 got=%b exp=10", ready); end
      n = 0;
      while (pll_rst[0] === 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n != RP) begin failures++; $display("FAIL retry_rst_pulse got=%0d exp=%0d", n, RP); end
   endtask

   task automatic test_saturation();
      int n, exp, model, timeouts;
      do_reset();
      lock = 2'b11;
      rst_n = 1'b1;
      wait_ready_all(n);
      model = 0;
      timeouts = 0;
      for (int e = 1; e <= 300; e++) begin
         lock = 2'b00;
         model = LOSS_EN ? ((model + 2 > 255) ? 255 : model + 2) : 0;
         exp_q.push_back(model);
         tick();
         lock = 2'b11;
         n = 0;
         while (ready !== 2'b00 && n < 10) begin tick(); n++; end
         exp = exp_q.pop_front();
         checks++; if (loss_cnt !== 8'(exp)) begin failures++; $display("FAIL sat_loss event=%0d got=%0d exp=%0d", e, loss_cnt, exp); end
         wait_ready_all(n);
         if (ready !== 2'b11) timeouts++;
      end
      checks++; if (timeouts != 0) begin failures++; $display("FAIL sat_relock_timeouts got=%0d exp=0", timeouts); end
   endtask

   task automatic test_async_reset();
      checks++; if (ready !== 2'b11) begin failures++; $display("FAIL async_pre_locked got=%b exp=11", ready); end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++; if (pll_rst !== 2'b11) begin failures++; $display("FAIL async_pll_rst got=%b exp=11", pll_rst); end
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL async_ready got=%b exp=00", ready); end
      checks++; if (fail !== 2'b00) begin failures++; $display("FAIL async_fail got=%b exp=00", fail); end
      checks++; if (sys_rst_n !== 1'b0) begin failures++; $display("FAIL async_sys got=%b exp=0", sys_rst_n); end
      checks++; if (loss_cnt !== 8'd0) begin failures++; $display("FAIL async_loss got=%0d exp=0", loss_cnt); end
   endtask

   initial begin
      rst_n = 1'b0;
      lock  = '0;
      retry = '0;
      test_reset();
      test_bringup();
      test_loss();
      test_glitch();
      test_stable_drop();
      test_fail_retry();
      test_saturation();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
